// File: rtl/dpram_sync_clr_if.sv
// Port bundle for the dual-port RAM: two access ports plus clear control/status.
// Latency: none, wiring only.
// Backpressure: BUSY from the RAM tells the master that port accesses are being dropped.
interface dpram_sync_clr_if #(
   parameter int A_WIDTH = 4,
   parameter int D_WIDTH = 16
);
   logic                   ENA;
   logic                   WEA;
   logic [D_WIDTH/8-1:0]   BEA;
   logic [A_WIDTH-1:0]     ADDRA;
   logic [D_WIDTH-1:0]     DIA;
   logic [D_WIDTH-1:0]     DOA;
   logic                   VALIDA;

   logic                   ENB;
   logic                   WEB;
   logic [D_WIDTH/8-1:0]   BEB;
   logic [A_WIDTH-1:0]     ADDRB;
   logic [D_WIDTH-1:0]     DIB;
   logic [D_WIDTH-1:0]     DOB;
   logic                   VALIDB;

   logic                   CLR;
   logic                   BUSY;
   logic                   COLL;

   modport master (
      output ENA, WEA, BEA, ADDRA, DIA,
      output ENB, WEB, BEB, ADDRB, DIB,
      output CLR,
      input  DOA, VALIDA, DOB, VALIDB, BUSY, COLL
   );

   modport slave (
      input  ENA, WEA, BEA, ADDRA, DIA,
      input  ENB, WEB, BEB, ADDRB, DIB,
      input  CLR,
      output DOA, VALIDA, DOB, VALIDB, BUSY, COLL
   );
endinterface

// File: rtl/dpram_sync_clr.sv
// True dual-port byte-write RAM with a sequential clear engine filling every word with CLR_VAL.
// Latency: read data + VALIDx one cycle after the accepting edge, two with OUT_REG=1.
// Backpressure: none per access; while BUSY (clearing) all port accesses are silently dropped.
module dpram_sync_clr #(
   parameter int                 A_WIDTH = 4,
   parameter int                 D_WIDTH = 16,
   parameter int                 RD_MODE = 0,
   parameter int                 OUT_REG = 0,
   parameter logic [D_WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST_N,
   dpram_sync_clr_if.slave  bus
);
   localparam int NB    = D_WIDTH / 8;
   localparam int DEPTH = 2 ** A_WIDTH;
   localparam logic [A_WIDTH-1:0] CNT_LAST = '1;

   typedef enum logic {S_CLEAR, S_READY} state_t;

   typedef logic [NB-1:0][7:0] word_t;

   state_t              state_q, state_d;
   logic [A_WIDTH-1:0]  cnt_q, cnt_d;
   logic                busy, clr_we;

   word_t               mem [DEPTH];
   word_t               dia_w, dib_w, old_a, old_b, new_a, new_b, rdat_a, rdat_b;
   logic                acc_a, acc_b, same_addr, coll_d;
   logic [NB-1:0]       be_a, be_b;

   logic [D_WIDTH-1:0]  do_a1, do_b1;
   logic                vld_a1, vld_b1, coll_q;

   assign dia_w     = bus.DIA;
   assign dib_w     = bus.DIB;
   assign same_addr = (bus.ADDRA == bus.ADDRB);

   // Clear-engine state and address counter; reset restarts the clear from word 0.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: walk the array once in CLEAR, wait for a CLR request in READY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      clr_we  = 1'b0;
      case (state_q)
         S_CLEAR: begin
            busy   = 1'b1;
            clr_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_READY;
               cnt_d   = '0;
            end
         end
         S_READY: begin
            if (bus.CLR) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // Access qualification and read-data selection. A port that actually writes
   // (some byte enabled) sees the final merged word in RD_MODE=1; a port that only
   // reads always sees the pre-write contents, even if the other port writes there.
   always_comb begin
      acc_a  = bus.ENA & ~busy;
      acc_b  = bus.ENB & ~busy;
      be_a   = (acc_a & bus.WEA) ? bus.BEA : '0;
      be_b   = (acc_b & bus.WEB) ? bus.BEB : '0;
      old_a  = mem[bus.ADDRA];
      old_b  = mem[bus.ADDRB];
      new_a  = old_a;
      new_b  = old_b;
      for (int i = 0; i < NB; i++) begin
         if (be_b[i] && same_addr) new_a[i] = dib_w[i];
         if (be_a[i])              new_a[i] = dia_w[i];
         if (be_b[i])              new_b[i] = dib_w[i];
         if (be_a[i] && same_addr) new_b[i] = dia_w[i];
      end
      rdat_a = (RD_MODE != 0 && (|be_a)) ? new_a : old_a;
      rdat_b = (RD_MODE != 0 && (|be_b)) ? new_b : old_b;
      coll_d = (|be_a) & (|be_b) & same_addr;
   end

   // Array writes: clear engine owns the array while busy; port A is applied after
   // port B so A wins any byte both ports enable on the same address.
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         mem[cnt_q] <= CLR_VAL;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (be_b[i]) mem[bus.ADDRB][i] <= dib_w[i];
         end
         for (int i = 0; i < NB; i++) begin
            if (be_a[i]) mem[bus.ADDRA][i] <= dia_w[i];
         end
      end
   end

   // First output stage: capture read data on accepted accesses, hold otherwise.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         do_a1  <= '0;
         do_b1  <= '0;
         vld_a1 <= 1'b0;
         vld_b1 <= 1'b0;
         coll_q <= 1'b0;
      end else begin
         vld_a1 <= acc_a;
         vld_b1 <= acc_b;
         coll_q <= coll_d;
         if (acc_a) do_a1 <= rdat_a;
         if (acc_b) do_b1 <= rdat_b;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [D_WIDTH-1:0] do_a2, do_b2;
         logic               vld_a2, vld_b2;

         // Optional second output stage, advanced only when stage one holds new data.
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               do_a2  <= '0;
               do_b2  <= '0;
               vld_a2 <= 1'b0;
               vld_b2 <= 1'b0;
            end else begin
               vld_a2 <= vld_a1;
               vld_b2 <= vld_b1;
               if (vld_a1) do_a2 <= do_a1;
               if (vld_b1) do_b2 <= do_b1;
            end
         end

         assign bus.DOA    = do_a2;
         assign bus.DOB    = do_b2;
         assign bus.VALIDA = vld_a2;
         assign bus.VALIDB = vld_b2;
      end else begin : g_no_out_reg
         assign bus.DOA    = do_a1;
         assign bus.DOB    = do_b1;
         assign bus.VALIDA = vld_a1;
         assign bus.VALIDB = vld_b1;
      end
   endgenerate

   assign bus.BUSY = busy;
   assign bus.COLL = coll_q;
endmodule

// File: doc/dpram_sync_clr.md
DPRAM_SYNC_CLR -- requirements
Module: dpram_sync_clr

Interface
REQ-001 The block SHALL provide parameter A_WIDTH, default 4: address width; depth is 2**A_WIDTH words.
REQ-002 The block SHALL provide parameter D_WIDTH, default 16: data width, a multiple of 8.
REQ-003 The block SHALL provide parameter RD_MODE, default 0: same-port read-during-write returns 0 = old data, 1 = new merged data.
REQ-004 The block SHALL provide parameter OUT_REG, default 0: 0 = read latency 1, 1 = read latency 2 via an extra output register.
REQ-005 The block SHALL provide parameter CLR_VAL, default 0: D_WIDTH-bit word written by the clear engine.
REQ-006 CLK  in  1  sole clock; all logic on the rising edge.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 ENA, ENB  in  1  per-port access enable.
REQ-009 WEA, WEB  in  1  per-port write enable, qualified by ENx.
REQ-010 BEA, BEB  in  D_WIDTH/8  per-port byte write enables; bit i covers DIx[8i+7:8i].
REQ-011 ADDRA, ADDRB  in  A_WIDTH  per-port word address.
REQ-012 DIA, DIB  in  D_WIDTH  per-port write data.
REQ-013 DOA, DOB  out  D_WIDTH  per-port read data, registered.
REQ-014 VALIDA, VALIDB  out  1  one-cycle pulse aligned with new DOx data.
REQ-015 CLR  in  1  synchronous request to refill the whole array with CLR_VAL.
REQ-016 BUSY  out  1  high while the clear engine runs; port accesses are ignored.
REQ-017 COLL  out  1  one-cycle pulse flagging a same-address dual write.

Function
REQ-018 The FSM SHALL have exactly two states: CLEAR and READY.
REQ-019 In CLEAR, one word per cycle SHALL be written with CLR_VAL at addresses 0..2**A_WIDTH-1 in ascending order; after the last write the FSM moves to READY; BUSY deasserts on the first READY cycle.
REQ-020 A CLR pulse sampled in READY SHALL move the FSM to CLEAR with the address counter at 0; CLR sampled in CLEAR SHALL be ignored.
REQ-021 While BUSY=1, ENA and ENB SHALL be treated as 0: no user write, no DOx update, VALIDx=0, COLL=0.
REQ-022 An access accepted at edge N SHALL present data on DOx and assert VALIDx after edge N+1 (OUT_REG=0) or edge N+2 (OUT_REG=1).
REQ-023 DOx SHALL hold its last value when no read completes.
REQ-024 A write (ENx=1, WEx=1) SHALL update only the bytes whose BEx bit is 1; BEx=0 with WEx=1 SHALL behave as a pure read.
REQ-025 Every accepted access, write or read, SHALL return read data for ADDRx: old word if RD_MODE=0, byte-merged new word if RD_MODE=1.
REQ-026 When one port writes an address that the other port only reads in the same cycle, the reader SHALL return the old word.
REQ-027 When both ports write the same address in the same cycle, port A SHALL win bytes enabled on both ports; bytes enabled on B only SHALL take DIB; COLL SHALL pulse for one cycle.
REQ-028 Writes to different addresses in the same cycle SHALL both complete, and COLL SHALL stay 0.
REQ-029 The address counter SHALL be A_WIDTH bits wide; CLEAR terminates on count 2**A_WIDTH-1 and does not wrap.

Reset
REQ-030 On RST_N=0, the block SHALL immediately force DOA=DOB=0, VALIDA=VALIDB=0, COLL=0, BUSY=1, FSM=CLEAR, counter=0, and clear the output pipeline.
REQ-031 RST_N SHALL not clear the array directly; the clear engine SHALL start on the first edge after RST_N rises.
REQ-032 A reset asserted mid-clear SHALL restart the clear from address 0.

Verification
REQ-033 The bench SHALL cover: reset release, A_WIDTH=4 -> BUSY high exactly 16 cycles; then a read of addr 7 returns 0x0000 with VALIDA 1 cycle later.
REQ-034 The bench SHALL cover: A writes 0xABCD @3 with BEA=2'b01, over 0x1234 -> memory 0x12CD; RD_MODE=0 DOA=0x1234, RD_MODE=1 DOA=0x12CD.
REQ-035 The bench SHALL cover: A writes 0x1111 BEA=2'b11 and B writes 0x2222 BEB=2'b11 to addr 5 in the same cycle -> word 0x1111, COLL pulses once; B BEB=2'b10 with A BEA=2'b01 -> 0x2211.
REQ-036 The bench SHALL cover: A writes 0x5555 @9 while B reads @9 holding 0xAAAA -> DOB=0xAAAA; next B read returns 0x5555.
REQ-037 The bench SHALL cover: OUT_REG=1, reads of @1,@2,@3 on consecutive cycles -> VALIDB on cycles N+2..N+4 with data in order.
REQ-038 The bench SHALL cover: CLR at READY, then RST_N pulse low at clear count 8 -> BUSY stays high, clear restarts at 0, 16 further BUSY cycles, every word = CLR_VAL.
